// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the IF-stage program-counter generator.
// State encodings, default PC width and default reset vector.
package pc_gen_pkg;

  localparam int unsigned PC_WIDTH_DEF  = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2
  } pcg_state_e;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Next-PC / next-state priority mux for pc_gen (purely combinational).
// In: state, pc, redirect/halt/wake/stall/ready inputs. Out: next_pc, next_state, strobes.
module pc_gen_next_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  pcg_state_e          state,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                stall_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  input  logic                br_valid_i,
  input  logic [PC_WIDTH-1:0] br_pc_i,
  input  logic                halt_i,
  input  logic                wake_i,
  input  logic                if_ready_i,
  output logic [PC_WIDTH-1:0] next_pc,
  output pcg_state_e          next_state,
  output logic                redirect,
  output logic                misalign
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
    PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [PC_WIDTH-1:0] trap_tgt;
  logic                br_ok;

  assign trap_tgt = trap_pc_i & ~ALIGN_MASK;
  assign br_ok    = (br_pc_i & ALIGN_MASK) == '0;

  always_comb begin
    next_pc    = pc;
    next_state = state;
    redirect   = 1'b0;
    misalign   = 1'b0;
    case (state)
      PCG_BOOT: next_state = PCG_RUN;
      PCG_RUN: begin
        if (trap_valid_i) begin
          next_pc  = trap_tgt;
          redirect = 1'b1;
        end else if (br_valid_i && br_ok) begin
          next_pc  = br_pc_i;
          redirect = 1'b1;
        end else if (br_valid_i) begin
          // Bad target is dropped; a concurrent halt still lands.
          misalign = 1'b1;
          if (halt_i) next_state = PCG_HALT;
        end else if (halt_i) begin
          next_state = PCG_HALT;
        end else if (!stall_i && if_ready_i) begin
          next_pc = pc + PC_WIDTH'(STEP);
        end
      end
      PCG_HALT: begin
        if (trap_valid_i) begin
          next_pc    = trap_tgt;
          next_state = PCG_RUN;
          redirect   = 1'b1;
        end else if (wake_i) begin
          next_state = PCG_RUN;
        end
      end
      default: next_state = PCG_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: state, PC and pulse registers.
// Ports: redirect/halt/wake/stall in; fetch request (if_valid_o/if_pc_o) and debug pulses out.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VEC  = PC_WIDTH'(RESET_VEC_DEF),
  parameter int unsigned         STEP       = 4,
  parameter int unsigned         ALIGN_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  input  logic                br_valid_i,
  input  logic [PC_WIDTH-1:0] br_pc_i,
  input  logic                halt_i,
  input  logic                wake_i,
  input  logic                if_ready_i,
  output logic                if_valid_o,
  output logic [PC_WIDTH-1:0] if_pc_o,
  output logic                redirect_o,
  output logic                br_misalign_o,
  output logic [1:0]          state_o
);

  pcg_state_e          state;
  pcg_state_e          next_state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                redirect;
  logic                misalign;

  pc_gen_next_sel #(
    .PC_WIDTH   (PC_WIDTH),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .state        (state),
    .pc           (pc),
    .stall_i      (stall_i),
    .trap_valid_i (trap_valid_i),
    .trap_pc_i    (trap_pc_i),
    .br_valid_i   (br_valid_i),
    .br_pc_i      (br_pc_i),
    .halt_i       (halt_i),
    .wake_i       (wake_i),
    .if_ready_i   (if_ready_i),
    .next_pc      (next_pc),
    .next_state   (next_state),
    .redirect     (redirect),
    .misalign     (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PCG_BOOT;
      pc            <= RESET_VEC;
      redirect_o    <= 1'b0;
      br_misalign_o <= 1'b0;
    end else begin
      state         <= next_state;
      pc            <= next_pc;
      redirect_o    <= redirect;
      br_misalign_o <= misalign;
    end
  end

  // Combinational from stall_i so a stall kills the request same cycle.
  assign if_valid_o = (state == PCG_RUN) && !stall_i;
  assign if_pc_o    = pc;
  assign state_o    = state;

endmodule
